// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, FSM states,
// datapath mux encodings and the bundled strobe record.
package cpu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_MEM_ADDR,
      ST_MEM_RD,
      ST_MEM_WB,
      ST_MEM_WR,
      ST_R_EXEC,
      ST_R_WB,
      ST_ADDI_EXEC,
      ST_ADDI_WB,
      ST_BRANCH,
      ST_JUMP,
      ST_ILLEGAL
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
      logic       instr_done;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps the current FSM state (plus the memory
// handshake and ALU zero flag) onto the datapath control strobes.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   zero,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         ST_FETCH: begin
            // PC+4 is computed every fetch cycle but only committed with the IR.
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         ST_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         ST_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ST_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_RT;
            ctrl.alu_op     = ALUOP_SUB;
            ctrl.pc_source  = PCSRC_ALUOUT;
            ctrl.pc_write   = zero;
            ctrl.instr_done = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.pc_write   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_ILLEGAL: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: state register, next-state logic and the
// retired-instruction counter around the combinational strobe decoder.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             illegal_op,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count
);

   state_t           state_reg;
   state_t           state_next;
   ctrl_t            ctrl;
   ctrl_t            ctrl_out;
   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_FETCH:     if (mem_ready) state_next = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = ST_MEM_ADDR;
               OP_RTYPE:     state_next = ST_R_EXEC;
               OP_BEQ:       state_next = ST_BRANCH;
               OP_J:         state_next = ST_JUMP;
               OP_ADDI:      state_next = ST_ADDI_EXEC;
               default:      state_next = ST_ILLEGAL;
            endcase
         end
         ST_MEM_ADDR:  state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:    if (mem_ready) state_next = ST_MEM_WB;
         ST_MEM_WR:    if (mem_ready) state_next = ST_FETCH;
         ST_R_EXEC:    state_next = ST_R_WB;
         ST_ADDI_EXEC: state_next = ST_ADDI_WB;
         ST_MEM_WB, ST_R_WB, ST_ADDI_WB,
         ST_BRANCH, ST_JUMP, ST_ILLEGAL:
                       state_next = ST_FETCH;
         default:      state_next = ST_FETCH;
      endcase
   end

   ctrl_decode u_decode (
      .state     (state_reg),
      .mem_ready (mem_ready),
      .zero      (zero),
      .ctrl      (ctrl)
   );

   // Counter wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (ctrl.instr_done) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   // Reset kills every strobe immediately, even though the state register
   // already sits in FETCH; a write-back in flight must not leak past reset.
   assign ctrl_out = reset ? CTRL_IDLE : ctrl;

   assign PCWrite     = ctrl_out.pc_write;
   assign IorD        = ctrl_out.iord;
   assign MemRead     = ctrl_out.mem_read;
   assign MemWrite    = ctrl_out.mem_write;
   assign IRWrite     = ctrl_out.ir_write;
   assign MemtoReg    = ctrl_out.mem_to_reg;
   assign RegDst      = ctrl_out.reg_dst;
   assign RegWrite    = ctrl_out.reg_write;
   assign ALUSrcA     = ctrl_out.alu_src_a;
   assign ALUSrcB     = ctrl_out.alu_src_b;
   assign ALUOp       = ctrl_out.alu_op;
   assign PCSource    = ctrl_out.pc_source;
   assign illegal_op  = ctrl_out.illegal_op;
   assign instr_done  = ctrl_out.instr_done;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected end-of-
// instruction strobes, a negedge monitor checks them when the DUT pulses.
module tb_multicycle_ctrl;

   localparam int CW = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] OP_JUNK = 6'b010101;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    opcode = '0;
   logic          zero = 1'b0;
   logic          mem_ready = 1'b0;
   logic          PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
   logic          RegDst, RegWrite, ALUSrcA, illegal_op, instr_done;
   logic [1:0]    ALUSrcB, ALUOp, PCSource;
   logic [CW-1:0] instr_count;
   logic [16:0]   strobes;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .illegal_op(illegal_op), .instr_done(instr_done), .instr_count(instr_count)
   );

   // Bit map: 16 PCWrite,15 IorD,14 MemRead,13 MemWrite,12 IRWrite,11 MemtoReg,
   // 10 RegDst,9 RegWrite,8 ALUSrcA,7:6 ALUSrcB,5:4 ALUOp,3:2 PCSource,1 illegal,0 done
   assign strobes = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_done};

   always #5 clk = ~clk;

   typedef struct {
      int            id;
      int            cyc;
      logic [16:0]   vec;
      logic [CW-1:0] cnt;
      int            mr;
   } exp_t;

   exp_t          sb[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            next_id = 0;
   logic [CW-1:0] exp_cnt = '0;
   int            mr_cnt = 0;
   int            ir_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [16:0] end_vec(input logic [5:0] op, input logic z);
      logic [16:0] v;
      v = '0;
      case (op)
         OP_LW:   begin v[9] = 1'b1; v[11] = 1'b1; v[0] = 1'b1; end
         OP_SW:   begin v[13] = 1'b1; v[15] = 1'b1; v[0] = 1'b1; end
         OP_R:    begin v[9] = 1'b1; v[10] = 1'b1; v[0] = 1'b1; end
         OP_ADDI: begin v[9] = 1'b1; v[0] = 1'b1; end
         OP_BEQ:  begin v[8] = 1'b1; v[5:4] = 2'b01; v[3:2] = 2'b01; v[16] = z; v[0] = 1'b1; end
         OP_J:    begin v[3:2] = 2'b10; v[16] = 1'b1; v[0] = 1'b1; end
         default: v[1] = 1'b1;
      endcase
      return v;
   endfunction

   function automatic int base_lat(input logic [5:0] op);
      case (op)
         OP_LW:                 return 5;
         OP_SW, OP_R, OP_ADDI:  return 4;
         default:               return 3;
      endcase
   endfunction

   // Runs one instruction from FETCH back to FETCH: fw fetch wait cycles,
   // mw wait cycles in MEM_RD/MEM_WR. mem_ready is low in every other cycle.
   task automatic run_instr(input logic [5:0] op, input logic z, input int fw,
                            input int mw, input int extra_mr);
      exp_t e;
      logic is_mem;
      int   n;
      is_mem = (op == OP_LW) || (op == OP_SW);
      n = base_lat(op) + fw + (is_mem ? mw : 0);
      e.id  = next_id;
      e.cyc = cyc + n - 1;
      e.vec = end_vec(op, z);
      e.cnt = exp_cnt;
      e.mr  = fw + 1 + ((op == OP_LW) ? mw + 1 : 0) + extra_mr;
      sb.push_back(e);
      $display("instr %0d: op=%b zero=%b fetch_wait=%0d mem_wait=%0d expect end cycle %0d",
               next_id, op, z, fw, mw, e.cyc);
      next_id++;
      if (op != OP_BAD) exp_cnt = exp_cnt + CW'(1);
      zero = z;
      for (int i = 0; i < n; i++) begin
         opcode    = (i <= fw) ? OP_JUNK : op;
         mem_ready = (i == fw) || (is_mem && (i == fw + 3 + mw));
         @(posedge clk); #1;
      end
   endtask

   // One stalled FETCH cycle right after reset release.
   task automatic fetch_probe();
      logic [16:0] v;
      v = '0;
      v[14] = 1'b1;
      v[7:6] = 2'b01;
      mem_ready = 1'b0;
      opcode = OP_JUNK;
      @(negedge clk);
      chk("fetch_after_reset strobes", strobes, v);
      chk("fetch_after_reset count", instr_count, exp_cnt);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         mr_cnt = 0;
         ir_cnt = 0;
      end else begin
         if (MemRead) mr_cnt++;
         if (IRWrite) ir_cnt++;
         if (instr_done || illegal_op) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got strobes=0x%0h at cycle %0d required no pulse",
                        strobes, cyc);
            end else begin
               e = sb.pop_front();
               chk($sformatf("instr%0d end_cycle", e.id), cyc, e.cyc);
               chk($sformatf("instr%0d strobes", e.id), strobes, e.vec);
               chk($sformatf("instr%0d count", e.id), instr_count, e.cnt);
               chk($sformatf("instr%0d memread_cycles", e.id), mr_cnt, e.mr);
               chk($sformatf("instr%0d irwrite_cycles", e.id), ir_cnt, 1);
               $display("instr %0d retired at cycle %0d strobes=0x%0h count=%0d",
                        e.id, cyc, strobes, instr_count);
            end
            mr_cnt = 0;
            ir_cnt = 0;
         end
      end
   end

   initial begin
      reset = 1'b1;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", strobes, 0);
      chk("reset_count", instr_count, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      fetch_probe();

      run_instr(OP_R,    1'b0, 0, 0, 1);
      run_instr(OP_LW,   1'b0, 0, 2, 0);
      run_instr(OP_SW,   1'b0, 1, 1, 0);
      run_instr(OP_ADDI, 1'b0, 0, 0, 0);
      run_instr(OP_BEQ,  1'b0, 0, 0, 0);
      run_instr(OP_BEQ,  1'b1, 0, 0, 0);
      run_instr(OP_J,    1'b0, 0, 0, 0);
      run_instr(OP_BAD,  1'b0, 0, 0, 0);
      run_instr(OP_J,    1'b1, 0, 0, 0);

      // lw up to MEM_WB, then reset in the middle of the write-back cycle.
      for (int i = 0; i < 4; i++) begin
         opcode    = (i == 0) ? OP_JUNK : OP_LW;
         mem_ready = (i == 0) || (i == 3);
         @(posedge clk); #1;
      end
      chk("pre_reset RegWrite", RegWrite, 1);
      chk("pre_reset count", instr_count, exp_cnt);
      reset = 1'b1;
      #1;
      chk("mid_wb_reset RegWrite", RegWrite, 0);
      chk("mid_wb_reset strobes", strobes, 0);
      chk("mid_wb_reset count", instr_count, 0);
      $display("reset asserted during lw write-back at cycle %0d", cyc);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = '0;
      fetch_probe();

      for (int k = 0; k < 15; k++) run_instr(OP_J, 1'b0, 0, 0, (k == 0) ? 1 : 0);
      chk("count_before_wrap", instr_count, exp_cnt);
      run_instr(OP_J, 1'b0, 0, 0, 0);
      chk("count_after_wrap", instr_count, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
